// File: rtl/led_brightness_sequencer.sv
// Pattern source for the 8-LED PWM stage: debounced mode/speed buttons, a shared
// animation phase, and a registered 64-bit bus of per-lane duty values.
module led_brightness_sequencer #(
  parameter int TICK_DIV        = 2097152,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        btn_mode,
  input  logic        btn_speed,
  output logic [63:0] duty_out,
  output logic        duty_update,
  output logic [1:0]  mode
);

  localparam logic [1:0] MODE_BREATHE = 2'd0;
  localparam logic [1:0] MODE_PHASED  = 2'd1;
  localparam logic [1:0] MODE_CHASE   = 2'd2;
  localparam logic [1:0] MODE_STATIC  = 2'd3;

  localparam int              TW         = $clog2(TICK_DIV);
  localparam int              DW         = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW:0]     TICK_DIV_W = (TW+1)'(TICK_DIV);
  localparam logic [DW-1:0]   DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    accepted;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt [2];

  logic          mode_press;
  logic          speed_press;
  logic [1:0]    speed;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_last;
  logic          tick;
  logic [8:0]    phase;
  logic          changed_q;
  logic          enable_q;
  logic          load;
  logic [63:0]   lanes;

  // Peak (255) and zero are each held for two phase steps.
  function automatic logic [7:0] tri_wave(input logic [8:0] p);
    return p[8] ? ~p[7:0] : p[7:0];
  endfunction

  assign btn_raw = {btn_speed, btn_mode};

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Index 0 debounces the mode button, index 1 the speed button.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      accepted <= '0;
      for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == accepted[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          accepted[b] <= sync2[b];
          db_cnt[b]   <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    press = '0;
    for (int b = 0; b < 2; b++)
      press[b] = sync2[b] && !accepted[b] && (db_cnt[b] == DB_LAST);
  end

  assign mode_press  = press[0];
  assign speed_press = press[1];

  assign tick_last = TW'((TICK_DIV_W >> speed) - (TW+1)'(1));
  assign tick      = enable && (tick_cnt == tick_last);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      speed    <= '0;
      tick_cnt <= '0;
    end else begin
      if (speed_press) speed <= speed + 2'd1;
      if (speed_press || !enable || tick) tick_cnt <= '0;
      else                                tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // A mode press restarts the animation and overrides a coincident tick.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      mode  <= MODE_BREATHE;
      phase <= '0;
    end else if (mode_press) begin
      mode  <= mode + 2'd1;
      phase <= '0;
    end else if (tick) begin
      phase <= phase + 9'd1;
    end
  end

  always_comb begin
    lanes = '0;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        MODE_BREATHE: lanes[8*i +: 8] = tri_wave(phase);
        MODE_PHASED:  lanes[8*i +: 8] = tri_wave(phase + 9'(64 * i));
        MODE_CHASE:   lanes[8*i +: 8] = (phase[8:6] == 3'(i)) ? 8'd255 : 8'd0;
        MODE_STATIC:  lanes[8*i +: 8] = 8'd128;
        default:      lanes[8*i +: 8] = 8'd0;
      endcase
    end
  end

  assign load = changed_q || (enable != enable_q);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      changed_q   <= 1'b0;
      enable_q    <= 1'b0;
      duty_out    <= '0;
      duty_update <= 1'b0;
    end else begin
      changed_q   <= mode_press || tick;
      enable_q    <= enable;
      duty_update <= load;
      if (load) duty_out <= enable ? lanes : 64'd0;
    end
  end

endmodule
